mux_logic_arbiter: RTL and testbench
====================================

# mux_logic_arbiter

Round-robin arbiter and sequencer that shares one 2:1-mux-based logic unit among `N_REQ` requesters. Each requester presents two 1-bit operands and a 2-bit opcode; the block grants one requester at a time, routes its operands through the shared mux unit configured for OR/AND/XOR/NOT, and returns a registered result with a one-cycle `done` pulse. It sits between the gate-level mux datapath and the per-requester control logic that previously instantiated a private mux gate each.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  request per requester; level, held until `done` with matching `gnt`
- `a`  in  N_REQ  operand A per requester (bit i = requester i)
- `b`  in  N_REQ  operand B per requester
- `op`  in  2*N_REQ  opcode per requester, bits [2i+1:2i]
- `gnt`  out  N_REQ  one-hot grant, all-zero when idle
- `result`  out  1  registered result, valid when `done`=1
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  high in EXEC and RESP

## Operation
- Reset: state=IDLE, `gnt`=0, `result`=0, `done`=0, `busy`=0, round-robin pointer `ptr`=0.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if `req`≠0, pick winner w = first set bit searching `ptr`, `ptr`+1, … wrapping at N_REQ-1→0; register `gnt`=1<<w; latch a[w], b[w], op[w]; `ptr`←(w+1) mod N_REQ; go EXEC. Else stay, outputs 0.
  - EXEC: shared mux unit evaluates latched operands; register its output into `result`; `done`←1; go RESP.
  - RESP: `done`=1, `gnt` and `result` held; next edge: `done`←0, `gnt`←0, go IDLE.
- Mux unit configuration (select = A always): op 00 OR: in0=B, in1=1. op 01 AND: in0=0, in1=B. op 10 XOR: in0=B, in1=~B. op 11 NOT A: in0=1, in1=0 (B ignored).
- Operands latched at grant; later changes to `a`/`b`/`op` of the winner do not affect the transaction.
- Winner dropping `req` during EXEC/RESP: transaction still completes, `done` still pulses; no abort.
- Requests arriving during EXEC/RESP are not sampled until IDLE.
- Simultaneous requests: only the round-robin winner is granted; others wait. No requester waits more than N_REQ-1 transactions.
- `rst` mid-transaction: immediate return to reset values, `done` not issued, latched operands discarded.

## Timing
- `req` seen at edge k (IDLE) → `gnt` high after edge k, `done`/`result` valid after edge k+1, `gnt`/`done` low after edge k+2.
- One transaction per 3 cycles; continuous requests yield `done` every 3rd cycle.
- `gnt` asserted exactly 2 cycles per transaction; `done` coincides with the second `gnt` cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package: opcode constants OP_OR=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_NOT=2'b11; state encoding IDLE/EXEC/RESP.
- One sub-module: `mux2_logic_unit` (combinational: a, b, op → y, built as a single 2:1 mux with operand-derived data inputs per table above). Arbiter/FSM/pointer in the top.

## Test plan
- Single request: req=0001, a[0]=1, b[0]=0, op[0]=OR → gnt=0001 one cycle later, done=1 with result=1 on the next, gnt=0000 after.
- Opcode sweep on requester 2: all four ops × all four (A,B) → result matches OR/AND/XOR/NOT truth tables (e.g. XOR 1,1→0; NOT A=0→1).
- Fairness: req=1111 held for 8 transactions from reset → grant order 0,1,2,3,0,1,2,3, done every 3rd cycle.
- Wrap/skip: after grant to 3, req=0101 → grant 0 then 2; after grant to 2 with req=0101 → grant 0.
- Operand/req change mid-transaction: change a[w], op[w] and drop req[w] in EXEC → result reflects latched values, done still pulses once.
- Async reset in EXEC → gnt, done, result, busy 0 immediately, no done pulse; next request from req=0010 granted to 1 (ptr=0).

Source files
------------

// File: rtl/mux_logic_arbiter_pkg.sv
// Shared opcode and FSM state encodings for the mux-based logic arbiter.
// Also provides the pointer-width helper used to size the round-robin pointer.
package mux_logic_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_logic_arbiter_if.sv
// Requester-side bundle: per-requester request/operands in, grant/result/status out.
// The master modport is the requester cluster, the slave modport is the arbiter.
interface mux_logic_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   a;
  logic [N_REQ-1:0]   b;
  logic [2*N_REQ-1:0] op;
  logic [N_REQ-1:0]   gnt;
  logic               result;
  logic               done;
  logic               busy;

  modport master (
    output req, a, b, op,
    input  gnt, result, done, busy
  );

  modport slave (
    input  req, a, b, op,
    output gnt, result, done, busy
  );

endinterface

// File: rtl/mux_logic_arbiter_mux2_logic_unit.sv
// Single 2:1 mux (select = a) whose data inputs are derived from b and the opcode.
// Purely combinational; no state, no backpressure.
module mux2_logic_unit
  import mux_logic_arbiter_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_e  op,
  output logic y
);

  logic in0;
  logic in1;

  always_comb begin
    in0 = 1'b0;
    in1 = 1'b0;
    unique case (op)
      OP_OR: begin
        in0 = b;
        in1 = 1'b1;
      end
      OP_AND: begin
        in0 = 1'b0;
        in1 = b;
      end
      OP_XOR: begin
        in0 = b;
        in1 = ~b;
      end
      OP_NOT: begin
        in0 = 1'b1;
        in1 = 1'b0;
      end
    endcase
  end

  assign y = a ? in1 : in0;

endmodule

// File: rtl/mux_logic_arbiter.sv
// Round-robin arbiter sharing one mux logic unit among N_REQ requesters.
// Three cycles per transaction (grant, evaluate, respond); losers simply hold req.
module mux_logic_arbiter
  import mux_logic_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic               clk,
  input logic               rst,
  mux_logic_arbiter_if.slave bus
);

  localparam int PW = ptr_width(N_REQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  op_e              op_q, op_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW:0]      cand_sum;
  logic [PW-1:0]    cand;
  logic             unit_y;

  // First set request at or after ptr_q, wrapping past N_REQ-1.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand_sum >= (PW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (PW+1)'(N_REQ);
      end
      cand = cand_sum[PW-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  mux2_logic_unit u_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (unit_y)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        done_d = 1'b0;
        busy_d = 1'b0;
        if (found) begin
          gnt_d   = N_REQ'(1) << win;
          a_d     = bus.a[win];
          b_d     = bus.b[win];
          op_d    = op_e'(bus.op[{win, 1'b0} +: 2]);
          ptr_d   = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = unit_y;
        done_d   = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        // result stays put so it can be read after done falls
        done_d  = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      result_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      op_q     <= OP_OR;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux_logic_arbiter.sv
// Scoreboarded bench for mux_logic_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_mux_logic_arbiter;
  import mux_logic_arbiter_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic       res;
    logic [7:0] gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_logic_arbiter_if #(.N_REQ(N)) bus ();

  mux_logic_arbiter #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       exp_q[$];
  exp_t       e;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         cyc = 0;
  int         last_done = 0;
  logic [3:0] prev_gnt = '0;

  // index = op*4 + a*2 + b
  bit sweep_exp [16] = '{0,1,1,1, 0,0,0,1, 0,1,1,0, 1,1,0,0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("done_with_empty_queue", 32'(bus.done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("gnt_at_done", 32'(bus.gnt), 32'(e.gnt));
        check("result", 32'(bus.result), 32'(e.res));
        check("gnt_cycle_before_done", 32'(prev_gnt), 32'(e.gnt));
        check("busy_at_done", 32'(bus.busy), 32'(1));
        if (e.gap != 0) check("done_spacing", 32'(cyc - last_done), 32'(e.gap));
      end
      last_done = cyc;
    end
    prev_gnt = bus.gnt;
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] av, input logic [3:0] bv,
                       input logic [7:0] opv);
    bus.req = r;
    bus.a   = av;
    bus.b   = bv;
    bus.op  = opv;
  endtask

  task automatic expect_txn(input logic [3:0] g, input logic r, input logic [7:0] gp);
    exp_t x;
    x.gnt = g;
    x.res = r;
    x.gap = gp;
    exp_q.push_back(x);
  endtask

  task automatic wait_dones(input int n);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 40 * n) begin
      @(negedge clk);
      t++;
      if (bus.done === 1'b1) seen++;
    end
    if (seen < n) check("done_timeout", 32'(seen), 32'(n));
  endtask

  task automatic run_one(input logic [3:0] r, input logic [3:0] av, input logic [3:0] bv,
                         input logic [7:0] opv, input logic [3:0] g, input logic res);
    @(posedge clk); #1;
    expect_txn(g, res, 8'd0);
    drive(r, av, bv, opv);
    wait_dones(1);
    @(posedge clk); #1;
    bus.req = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [3:0] iv;
    rst = 1'b1;
    drive('0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 32'(bus.gnt), 32'(0));
    check("reset_result", 32'(bus.result), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // single request, OR(1,0) on requester 0, with cycle-exact timing
    @(posedge clk); #1;
    expect_txn(4'b0001, 1'b1, 8'd0);
    drive(4'b0001, 4'b0001, 4'b0000, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("single_gnt_after_k", 32'(bus.gnt), 32'(4'b0001));
    check("single_done_low_after_k", 32'(bus.done), 32'(0));
    check("single_busy_exec", 32'(bus.busy), 32'(1));
    @(negedge clk);
    check("single_done_after_k1", 32'(bus.done), 32'(1));
    @(negedge clk);
    check("single_gnt_low_after_k2", 32'(bus.gnt), 32'(0));
    check("single_done_low_after_k2", 32'(bus.done), 32'(0));
    bus.req = '0;

    // opcode sweep on requester 2
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      run_one(4'b0100, {1'b0, iv[1], 2'b00}, {1'b0, iv[0], 2'b00},
              {2'b00, iv[3:2], 4'h0}, 4'b0100, sweep_exp[i]);
    end

    // fairness from reset with all requesting: result equals a[i] under OR with b=0
    do_reset();
    for (int t = 0; t < 8; t++) begin
      expect_txn(4'(1 << (t % 4)), (t % 2 == 0) ? 1'b1 : 1'b0, (t == 0) ? 8'd0 : 8'd3);
    end
    @(posedge clk); #1;
    drive(4'b1111, 4'b0101, 4'b0000, 8'h00);
    wait_dones(8);
    @(posedge clk); #1;
    bus.req = '0;

    // wrap/skip: ptr is 0 after grant to 3
    expect_txn(4'b0001, 1'b1, 8'd0);
    expect_txn(4'b0100, 1'b0, 8'd3);
    expect_txn(4'b0001, 1'b1, 8'd3);
    @(posedge clk); #1;
    drive(4'b0101, 4'b0001, 4'b0000, 8'h00);
    wait_dones(3);
    @(posedge clk); #1;
    bus.req = '0;

    // mid-transaction change: latched XOR(1,0)=1, live inputs become AND(0,1)=0 and req drops
    d0 = n_done;
    expect_txn(4'b0010, 1'b1, 8'd0);
    @(posedge clk); #1;
    drive(4'b0010, 4'b0010, 4'b0000, 8'h08);
    @(posedge clk); #1;
    drive(4'b0000, 4'b0000, 4'b0010, 8'h04);
    wait_dones(1);
    repeat (6) @(negedge clk);
    check("mid_change_single_done", 32'(n_done - d0), 32'(1));

    // async reset during EXEC of requester 1 (pointer would otherwise be 2)
    @(posedge clk); #1;
    drive(4'b0010, 4'b0010, 4'b0010, 8'h04);
    @(posedge clk); #1;
    d0 = n_done;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(bus.gnt), 32'(0));
    check("arst_done", 32'(bus.done), 32'(0));
    check("arst_result", 32'(bus.result), 32'(0));
    check("arst_busy", 32'(bus.busy), 32'(0));
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_no_done", 32'(n_done - d0), 32'(0));
    // pointer back at 0: 0110 must go to requester 1; NOT(0)=1
    run_one(4'b0110, 4'b0000, 4'b0000, 8'h0C, 4'b0010, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
